// File: rtl/dbl_stream_pkg.sv
// Shared types and constants for the byte-to-double stream path.
package dbl_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bytes per IEEE-754 double word.
  localparam int DBL_BYTES = 8;

endpackage

// File: rtl/byte_to_double_packer.sv
// Byte-to-double packer: drops a leading byte offset, then assembles
// little-endian 64-bit words from an 8-bit stream into a one-entry
// output register with valid/ready flow control.
module byte_to_double_packer
  import dbl_stream_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int OFF_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OFF_W-1:0] offset,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int ACC_W = (DBL_BYTES - 1) * 8;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OFF_W-1:0] r_skip_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic [2:0]       r_byte_idx;
  logic [ACC_W-1:0] r_acc;        // first 7 bytes of the word in flight
  logic [63:0]      r_out_data;
  logic             r_out_valid;
  logic             r_last_loaded;  // final word sits in the output register

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_start_ok;
  logic             w_skip_last;
  logic             w_word_end;
  logic [LEN_W-1:0] w_word_cnt_nxt;

  assign w_start_ok     = (r_state == ST_IDLE) && start;
  assign w_in_fire      = in_valid && w_in_ready;
  assign w_out_fire     = r_out_valid && out_ready;
  assign w_skip_last    = (r_state == ST_SKIP) && w_in_fire && (r_skip_cnt == OFF_W'(1));
  assign w_word_end     = (r_state == ST_PACK) && w_in_fire &&
                          (r_byte_idx == 3'(DBL_BYTES - 1));
  assign w_word_cnt_nxt = r_word_cnt + LEN_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; the final word must drain before DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (offset != '0)      w_state_nxt = ST_SKIP;
          else if (length != '0) w_state_nxt = ST_PACK;
          else                   w_state_nxt = ST_DONE;
        end
      end
      ST_SKIP: begin
        if (w_skip_last) w_state_nxt = (r_len != '0) ? ST_PACK : ST_DONE;
      end
      ST_PACK: begin
        if (r_last_loaded && w_out_fire) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the 8th byte stalls only if the output register cannot drain.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_SKIP: w_in_ready = 1'b1;
      ST_PACK: w_in_ready = !r_last_loaded &&
                            !((r_byte_idx == 3'(DBL_BYTES - 1)) && r_out_valid && !out_ready);
      default: w_in_ready = 1'b0;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Skip/word counters, byte assembly and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip_cnt    <= '0;
      r_len         <= '0;
      r_word_cnt    <= '0;
      r_byte_idx    <= '0;
      r_acc         <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_last_loaded <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_skip_cnt    <= offset;
        r_len         <= length;
        r_word_cnt    <= '0;
        r_byte_idx    <= '0;
        r_last_loaded <= 1'b0;
      end else if ((r_state == ST_SKIP) && w_in_fire) begin
        r_skip_cnt <= r_skip_cnt - OFF_W'(1);
      end else if ((r_state == ST_PACK) && w_in_fire) begin
        r_byte_idx <= r_byte_idx + 3'd1;  // wraps 7 -> 0 at word end
        if (w_word_end) begin
          r_word_cnt    <= w_word_cnt_nxt;
          r_last_loaded <= (w_word_cnt_nxt == r_len);
        end else begin
          // Shift right so the earliest byte lands in the lowest lane.
          r_acc <= {in_data, r_acc[ACC_W-1:8]};
        end
      end

      if (w_word_end) begin
        r_out_data  <= {in_data, r_acc};
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_to_double_packer.sv
// Randomized bench for byte_to_double_packer with a queue-based word model.
module tb_byte_to_double_packer;

  localparam int LEN_W = 16;
  localparam int OFF_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [OFF_W-1:0] offset;
  logic [LEN_W-1:0] length;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] src_q[$];

  byte_to_double_packer #(.LEN_W(LEN_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst), .start(start), .offset(offset), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer. Entered and left at #1 after a rising edge.
  task automatic do_xfer(input int off, input int len, input int vprob, input int rprob,
                         input int stall_cyc, input int restart_at, input bit chk_block,
                         output logic [63:0] last_word, output int done_cyc);
    logic [63:0] exp_q[$];
    logic [63:0] w;
    int consumed = 0;
    int nwords = 0;
    bit fin = 0;
    int cyc;
    last_word = '0;
    done_cyc  = -1;
    while (src_q.size() < off + 8 * len + 4) src_q.push_back(8'($urandom));
    for (int i = 0; i < len; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w = w | (64'(src_q[off + 8 * i + k]) << (8 * k));
      exp_q.push_back(w);
    end
    start  = 1'b1;
    offset = OFF_W'(off);
    length = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; !fin && cyc < 3000; cyc++) begin
      in_valid  = (consumed < src_q.size()) && ($urandom_range(99) < vprob);
      in_data   = (consumed < src_q.size()) ? src_q[consumed] : 8'($urandom);
      out_ready = (cyc < stall_cyc) ? 1'b0 : ($urandom_range(99) < rprob);
      if (cyc == restart_at) begin
        start  = 1'b1;
        offset = '0;
        length = LEN_W'(len + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("busy_in_xfer", busy, 1'b1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("extra_word", out_valid, 1'b0);
        else                   chk("out_data", out_data, exp_q[0]);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        last_word = out_data;
        void'(exp_q.pop_front());
        nwords++;
      end
      if (in_valid && in_ready) consumed++;
      if (chk_block && cyc == stall_cyc - 1) begin
        chk("in_ready_byte16", in_ready, 1'b0);
        chk("bytes_before_block", consumed, 15);
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    chk("timeout", fin, 1'b1);
    chk("word_count", nwords, len);
    chk("bytes_consumed", consumed, off + 8 * len);
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] lw;
    int dc;
    rst = 1'b1; start = 1'b0; offset = '0; length = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1.0
    src_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h3F};
    do_xfer(0, 1, 100, 100, 0, -1, 0, lw, dc);
    chk("word_1p0", lw, 64'h3FF0000000000000);

    // pi after three dropped bytes
    src_q = {8'hAA, 8'hBB, 8'hCC, 8'h18, 8'h2D, 8'h44, 8'h54, 8'hFB, 8'h21, 8'h09, 8'h40};
    do_xfer(3, 1, 100, 100, 0, -1, 0, lw, dc);
    chk("word_pi", lw, 64'h400921FB54442D18);

    // back-pressure: out_ready low for 20 cycles
    src_q.delete();
    do_xfer(0, 3, 100, 100, 20, -1, 1, lw, dc);

    // zero length
    src_q.delete();
    do_xfer(0, 0, 100, 100, 0, -1, 0, lw, dc);
    chk("len0_done_latency", dc, 0);

    // start pulsed while busy
    src_q.delete();
    do_xfer(1, 2, 80, 80, 0, 3, 0, lw, dc);

    // reset in the middle of a word; start raised with rst must be ignored
    start = 1'b1; offset = '0; length = LEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 64'h0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    src_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_xfer(0, 1, 100, 100, 0, -1, 0, lw, dc);
    chk("word_after_rst", lw, 64'h8877665544332211);

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      src_q.delete();
      do_xfer($urandom_range(5), $urandom_range(4), $urandom_range(100, 50),
              $urandom_range(100, 30), $urandom_range(6), -1, 0, lw, dc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/byte_to_double_packer.md
BYTE_TO_DOUBLE_PACKER -- requirements
Module: byte_to_double_packer

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-002 SHALL have parameter OFF_W, default 32, width of the byte-offset input.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a transfer; accepted only in IDLE.
REQ-006 SHALL have port offset, input, OFF_W, number of leading input bytes to discard; sampled on accepted start.
REQ-007 SHALL have port length, input, LEN_W, number of 64-bit words to emit; sampled on accepted start.
REQ-008 SHALL have ports in_data (input, 8, byte stream), in_valid (input, 1) and in_ready (output, 1).
REQ-009 SHALL have ports out_data (output, 64, assembled IEEE-754 double bits), out_valid (output, 1) and out_ready (input, 1).
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when a transfer completes.

Function
REQ-012 SHALL have states IDLE, SKIP, PACK and DONE.
REQ-013 SHALL make these transitions:
- IDLE -> SKIP on start with offset != 0.
- IDLE -> PACK on start with offset == 0 and length != 0.
- IDLE -> DONE on start with offset == 0 and length == 0.
REQ-014 SHALL, in SKIP, assert in_ready and discard one byte per in_valid handshake; after the offset-th discarded byte it goes to PACK, or to DONE if length == 0.
REQ-015 SHALL, in PACK, place byte k (k = 0..7) of each word into out_data bits [8k+7:8k] (little-endian), so the first byte received is the LSB.
REQ-016 SHALL keep a 3-bit byte index that wraps from 7 to 0 when a word completes.
REQ-017 SHALL keep in_ready high in PACK except on the 8th byte of a word while out_valid is high and out_ready is low.
REQ-018 SHALL load out_data and set out_valid in the cycle after the 8th byte handshake, giving one cycle of latency.
REQ-019 SHALL allow a simultaneous out_ready drain and reload with no bubble.
REQ-020 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-021 SHALL clear out_valid after an out handshake unless a new word loads in the same cycle.
REQ-022 SHALL keep a word counter; when the length-th word is loaded into the output register, it stops accepting input (in_ready low) and waits for that word's out handshake before entering DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-024 SHALL ignore start while busy is high.
REQ-025 SHALL, in IDLE and DONE, hold in_ready low and ignore in_valid.
REQ-026 SHALL discard a partially assembled word on reset; no output is produced for it.

Reset
REQ-027 SHALL, on rst high at a clock edge, go to IDLE and drive out_valid=0, out_data=0, in_ready=0, busy=0, done=0, with byte index and counters cleared.
REQ-028 SHALL let rst override start and all handshakes in the same cycle, and SHALL accept start in the first cycle after rst falls.

Structure
REQ-029 SHALL take the state enum typedef and constant DBL_BYTES=8 from shared package dbl_stream_pkg.
REQ-030 SHALL be implemented as a single module with no sub-modules; the output holding register is inline.

Verification
REQ-031 SHALL cover: start, offset=0, length=1, bytes 00 00 00 00 00 00 F0 3F -> one output 0x3FF0000000000000 (1.0), then a done pulse.
REQ-032 SHALL cover: offset=3, length=1, bytes AA BB CC then 18 2D 44 54 FB 21 09 40 -> AA/BB/CC dropped, output 0x400921FB54442D18 (pi).
REQ-033 SHALL cover: length=3, out_ready held low for 20 cycles -> first word held stable, in_ready low on byte 16, no data lost after release, 3 words in order.
REQ-034 SHALL cover: length=0, offset=0 -> done one cycle after start, out_valid never asserted.
REQ-035 SHALL cover: rst after 5 bytes of a word -> all outputs at reset values; a new start with length=1 yields a word built from fresh bytes only.
REQ-036 SHALL cover: start pulsed again while busy -> ignored; the original length is honoured.
